// File: rtl/mult_pkg.sv
// Shared widths and FSM encoding for the
// shift-and-add sequential multiplier.
package mult_pkg;

  localparam int WIDTH       = 32;
  localparam int PROD_WIDTH  = 64;
  localparam int COUNT_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_multiplier_adder.sv
// Ripple-carry adder used for the
// multiplier accumulate step.
module adder
  import mult_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  logic [WIDTH:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i])
                    | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// 32x32 unsigned shift-and-add multiplier,
// one partial product per clock.
module seq_multiplier
  import mult_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  output logic                  busy,
  output logic                  done,
  output logic [PROD_WIDTH-1:0] product
);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic [PROD_WIDTH-1:0]  prod_q, prod_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_co;

  assign add_b = prod_q[0] ? mcand_q : '0;

  adder u_adder (
    .a     (prod_q[PROD_WIDTH-1:WIDTH]),
    .b     (add_b),
    .c_in  (1'b0),
    .sum   (add_sum),
    .c_out (add_co)
  );

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          prod_d  = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // carry-out lands in the top bit each step
        prod_d = {add_co, add_sum,
                  prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == COUNT_WIDTH'(WIDTH - 1))
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy    = (state_q == BUSY);
  assign done    = (state_q == DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks for
// seq_multiplier.
module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;
  logic done_prev = 1'b0;

  seq_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    string       nm;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // done must never be high two samples running
  always @(negedge clk) begin
    if (done) chk("done_width", 64'(done_prev), 64'd0);
    done_prev = done;
  end

  task automatic launch(input logic [31:0] ta,
                        input logic [31:0] tb);
    a = ta;
    b = tb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n,
                           output int bc);
    n  = 0;
    bc = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      compared++;
      failed++;
      $display("FAIL timeout: no done after %0d cycles", n);
    end
  endtask

  task automatic finish_op(input logic [63:0] exp,
                           input string nm);
    int n, bc;
    wait_done(n, bc);
    chk({nm, "_latency"}, 64'(n), 64'd32);
    chk({nm, "_busycyc"}, 64'(bc), 64'd32);
    chk({nm, "_product"}, product, exp);
    chk({nm, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({nm, "_done_fall"}, 64'(done), 64'd0);
    chk({nm, "_hold"}, product, exp);
  endtask

  task automatic mul(input logic [31:0] ta,
                     input logic [31:0] tb,
                     input logic [63:0] exp,
                     input string nm);
    launch(ta, tb);
    chk({nm, "_busy_rise"}, 64'(busy), 64'd1);
    finish_op(exp, nm);
  endtask

  initial begin
    int n, bc, t1, t2;
    logic [31:0] ra, rb;

    vecs[0] = '{32'd3, 32'd5, 64'h0F, "v3x5"};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF,
                64'hFFFFFFFE00000001, "vmax"};
    vecs[2] = '{32'd0, 32'hDEADBEEF, 64'd0, "vzero_a"};
    vecs[3] = '{32'hDEADBEEF, 32'd0, 64'd0, "vzero_b"};
    vecs[4] = '{32'd1, 32'hFFFFFFFF,
                64'h00000000FFFFFFFF, "v1xmax"};
    vecs[5] = '{32'hFFFFFFFF, 32'd1,
                64'h00000000FFFFFFFF, "vmaxx1"};
    vecs[6] = '{32'h00010000, 32'h00010000,
                64'h0000000100000000, "v2p16sq"};
    vecs[7] = '{32'd12345, 32'd6789,
                64'd83810205, "v12345"};
    vecs[8] = '{32'h80000000, 32'd2,
                64'h0000000100000000, "vmsb"};
    vecs[9] = '{32'd1000, 32'd1000,
                64'd1000000, "v1000sq"};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", product, 64'd0);

    // reset wins over start
    start = 1'b1;
    a = 32'd9;
    b = 32'd9;
    @(negedge clk);
    chk("rst_over_start", 64'(busy), 64'd0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_hold_busy", 64'(busy), 64'd0);
    chk("idle_hold_prod", product, 64'd0);

    foreach (vecs[i])
      mul(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].nm);

    // start held through BUSY and DONE
    a = 32'd7;
    b = 32'd9;
    start = 1'b1;
    @(negedge clk);
    a = 32'd2;
    b = 32'd2;
    wait_done(n, bc);
    chk("hold_latency", 64'(n), 64'd32);
    chk("hold_product", product, 64'd63);
    @(negedge clk);
    chk("hold_idle_busy", 64'(busy), 64'd0);
    chk("hold_idle_prod", product, 64'd63);
    @(negedge clk);
    chk("hold_restart", 64'(busy), 64'd1);
    start = 1'b0;
    finish_op(64'd4, "hold2");

    // reset mid-operation
    launch(32'd1000, 32'd1000);
    repeat (10) @(negedge clk);
    chk("mid_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_prod", product, 64'd0);
    rst = 1'b0;
    launch(32'd1000, 32'd1000);
    chk("post_rst_accept", 64'(busy), 64'd1);
    finish_op(64'd1000000, "post_rst");

    // back-to-back with start held high
    a = 32'h80000000;
    b = 32'd2;
    start = 1'b1;
    @(negedge clk);
    a = 32'd12345;
    b = 32'd6789;
    wait_done(n, bc);
    t1 = cyc;
    chk("b2b_p1", product, 64'h0000000100000000);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_accept2", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(n, bc);
    t2 = cyc;
    chk("b2b_p2", product, 64'd83810205);
    chk("b2b_spacing", 64'(t2 - t1), 64'd34);
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 50 == 0) ra = 32'hFFFFFFFF;
      if (i % 70 == 0) rb = 32'hFFFFFFFF;
      if (i % 97 == 0) ra = 32'd0;
      mul(ra, rb, {32'd0, ra} * {32'd0, rb}, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, failed);
    $finish;
  end

endmodule
